// File: rtl/dsa_core_dispatch.sv
// Dispatcher and sequencer between the control plane, NUM_CORES bilinear cores and the shared BRAMs.
// Owns the output-memory clear engine, the run watchdog, sticky error flags and the perf-counter mux.
module dsa_core_dispatch #(
  parameter int unsigned NUM_CORES   = 3,
  parameter int unsigned AW          = 12,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned CLEAR_DEPTH = 4096,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  input  logic                    start_req,
  input  logic                    clear_req,
  input  logic [SEL_W-1:0]        mode_sel,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES-1:0]    core_abort,
  input  logic [NUM_CORES-1:0]    core_busy,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*AW-1:0] core_raddr,
  input  logic [NUM_CORES*AW-1:0] core_waddr,
  input  logic [NUM_CORES*8-1:0]  core_wdata,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES*96-1:0] core_perf,
  output logic [AW-1:0]           mem_in_raddr,
  output logic [AW-1:0]           mem_out_waddr,
  output logic [7:0]              mem_out_wdata,
  output logic                    mem_out_we,
  output logic                    in_we_allow,
  output logic                    busy,
  output logic                    done_latched,
  output logic [SEL_W-1:0]        active_core,
  output logic [31:0]             cycle_count,
  output logic [95:0]             perf_out,
  output logic [1:0]              err_flags
);

  localparam int unsigned NSLOT  = 1 << SEL_W;
  localparam int unsigned PERF_W = 96;
  localparam int unsigned DW     = 8;
  localparam logic [AW-1:0]    CLEAR_LAST = AW'(CLEAR_DEPTH - 1);
  localparam logic [SEL_W:0]   NC_LIM     = (SEL_W+1)'(NUM_CORES);
  localparam logic [31:0]      TO_LAST    = 32'(TIMEOUT_CYC - 1);
  localparam bit               TO_EN      = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AW-1:0]     clear_addr_q;
  logic              start_pend_q;

  // Per-core buses re-packed into slots indexable by the full mode_sel width;
  // slots beyond NUM_CORES read as zero and are never selected.
  logic [AW-1:0]     raddr_s [NSLOT];
  logic [AW-1:0]     waddr_s [NSLOT];
  logic [DW-1:0]     wdata_s [NSLOT];
  logic [PERF_W-1:0] perf_s  [NSLOT];
  logic [NSLOT-1:0]  we_s;
  logic [NSLOT-1:0]  done_s;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NUM_CORES) begin : g_core
      assign raddr_s[i] = core_raddr[i*AW +: AW];
      assign waddr_s[i] = core_waddr[i*AW +: AW];
      assign wdata_s[i] = core_wdata[i*DW +: DW];
      assign perf_s[i]  = core_perf[i*PERF_W +: PERF_W];
      assign we_s[i]    = core_we[i];
      assign done_s[i]  = core_done[i];
    end else begin : g_empty
      assign raddr_s[i] = '0;
      assign waddr_s[i] = '0;
      assign wdata_s[i] = '0;
      assign perf_s[i]  = '0;
      assign we_s[i]    = 1'b0;
      assign done_s[i]  = 1'b0;
    end
  end

  // Per-core busy is for the control plane only; sequencing keys off done.
  logic unused_core_busy;
  assign unused_core_busy = ^core_busy;

  logic launch_req;
  logic sel_ok;
  logic done_act;
  logic timeout_hit;

  assign launch_req  = start_req | start_pend_q;
  assign sel_ok      = ({1'b0, mode_sel} < NC_LIM);
  assign done_act    = done_s[active_core];
  assign timeout_hit = TO_EN && (cycle_count == TO_LAST);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clear_addr_q == CLEAR_LAST) state_d = ST_IDLE;
      ST_IDLE: begin
        if (clear_req)                 state_d = ST_CLEAR;
        else if (launch_req && sel_ok) state_d = ST_RUN;
      end
      ST_RUN:  if (done_act || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Output-memory routing: clear engine owns the port in CLEAR, the locked core in RUN.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    in_we_allow   = (state_q == ST_IDLE);
    mem_in_raddr  = raddr_s[active_core];
    mem_out_waddr = waddr_s[active_core];
    mem_out_wdata = wdata_s[active_core];
    mem_out_we    = 1'b0;
    perf_out      = perf_s[active_core];
    case (state_q)
      ST_CLEAR: begin
        mem_out_waddr = clear_addr_q;
        mem_out_wdata = '0;
        mem_out_we    = 1'b1;
      end
      ST_RUN:  mem_out_we = we_s[active_core];
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      clear_addr_q <= '0;
      start_pend_q <= 1'b0;
      core_start   <= '0;
      core_abort   <= '0;
      done_latched <= 1'b0;
      active_core  <= '0;
      cycle_count  <= '0;
      err_flags    <= '0;
    end else begin
      core_start <= '0;
      core_abort <= '0;
      case (state_q)
        ST_CLEAR: begin
          clear_addr_q <= (clear_addr_q == CLEAR_LAST) ? '0 : clear_addr_q + AW'(1);
          if (start_req) start_pend_q <= 1'b1;
        end
        ST_IDLE: begin
          if (clear_req) begin
            clear_addr_q <= '0;
            if (start_req) start_pend_q <= 1'b1;
          end else if (launch_req) begin
            start_pend_q <= 1'b0;
            if (sel_ok) begin
              active_core  <= mode_sel;
              core_start   <= NUM_CORES'(1) << mode_sel;
              done_latched <= 1'b0;
              cycle_count  <= '0;
              err_flags    <= '0;
            end else begin
              err_flags[0] <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
          // A done arriving on the watchdog's last cycle still counts as success.
          if (done_act) begin
            done_latched <= 1'b1;
          end else if (timeout_hit) begin
            core_abort   <= NUM_CORES'(1) << active_core;
            err_flags[1] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_core_dispatch.sv
// Directed bench for dsa_core_dispatch: clear sweep, pending start, routing lock, watchdog, bad mode.
module tb_dsa_core_dispatch;

  localparam int unsigned NC = 3;
  localparam int unsigned AW = 12;
  localparam int unsigned SW = 3;
  localparam int unsigned CD = 4096;
  localparam int unsigned TO = 1000;

  logic              clk_50 = 1'b0;
  logic              rst_n  = 1'b1;
  logic              start_req, clear_req;
  logic [SW-1:0]     mode_sel;
  logic [NC-1:0]     core_start, core_abort, core_busy, core_done, core_we;
  logic [NC*AW-1:0]  core_raddr, core_waddr;
  logic [NC*8-1:0]   core_wdata;
  logic [NC*96-1:0]  core_perf;
  logic [AW-1:0]     mem_in_raddr, mem_out_waddr;
  logic [7:0]        mem_out_wdata;
  logic              mem_out_we, in_we_allow, busy, done_latched;
  logic [SW-1:0]     active_core;
  logic [31:0]       cycle_count;
  logic [95:0]       perf_out;
  logic [1:0]        err_flags;

  localparam logic [95:0] PERF0 = 96'h00000010_00000011_00000012;
  localparam logic [95:0] PERF1 = 96'h00000020_00000021_00000022;
  localparam logic [95:0] PERF2 = 96'h00000030_00000031_00000032;

  dsa_core_dispatch #(
    .NUM_CORES(NC), .AW(AW), .SEL_W(SW), .CLEAR_DEPTH(CD), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .start_req(start_req), .clear_req(clear_req),
    .mode_sel(mode_sel), .core_start(core_start), .core_abort(core_abort),
    .core_busy(core_busy), .core_done(core_done), .core_raddr(core_raddr),
    .core_waddr(core_waddr), .core_wdata(core_wdata), .core_we(core_we),
    .core_perf(core_perf), .mem_in_raddr(mem_in_raddr), .mem_out_waddr(mem_out_waddr),
    .mem_out_wdata(mem_out_wdata), .mem_out_we(mem_out_we), .in_we_allow(in_we_allow),
    .busy(busy), .done_latched(done_latched), .active_core(active_core),
    .cycle_count(cycle_count), .perf_out(perf_out), .err_flags(err_flags)
  );

  always #10 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int launch_cyc;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  // Walks a full clear from its first cycle; optionally raises start_req on one cycle.
  task automatic clear_sweep(input int pulse_at);
    int bad = 0;
    for (int j = 0; j < int'(CD); j++) begin
      if (!(mem_out_we === 1'b1 && mem_out_waddr === AW'(j) && mem_out_wdata === 8'h00 &&
            busy === 1'b1 && in_we_allow === 1'b0 && core_start === '0)) bad++;
      if (j == pulse_at) start_req = 1'b1;
      tick();
      start_req = 1'b0;
    end
    check("clear_sweep", 96'(bad), 96'd0);
  endtask

  initial begin
    start_req  = 1'b0;
    clear_req  = 1'b0;
    mode_sel   = '0;
    core_busy  = '0;
    core_done  = '0;
    core_we    = 3'b111;
    core_raddr = {12'h0C2, 12'h0C1, 12'h0C0};
    core_waddr = {12'h222, 12'h111, 12'h100};
    core_wdata = {8'h5C, 8'hA1, 8'hA0};
    core_perf  = {PERF2, PERF1, PERF0};

    #3 rst_n = 1'b0;
    #1;
    check("rst_busy",      96'(busy),          96'd1);
    check("rst_we",        96'(mem_out_we),    96'd1);
    check("rst_waddr",     96'(mem_out_waddr), 96'd0);
    check("rst_start",     96'(core_start),    96'd0);
    check("rst_done",      96'(done_latched),  96'd0);
    check("rst_err",       96'(err_flags),     96'd0);
    check("rst_cnt",       96'(cycle_count),   96'd0);
    check("rst_allow",     96'(in_we_allow),   96'd0);
    check("rst_perf",      perf_out,           PERF0);
    tick();
    tick();
    rst_n    = 1'b1;
    mode_sel = 3'd1;

    // Power-up clear with a start request parked at clear cycle 100; core writes must stay blocked.
    clear_sweep(100);
    core_we = '0;
    check("idle_busy",     96'(busy),          96'd0);
    check("idle_allow",    96'(in_we_allow),   96'd1);
    check("idle_we",       96'(mem_out_we),    96'd0);
    check("idle_nostart",  96'(core_start),    96'd0);
    tick();
    launch_cyc = cyc;
    check("pend_start",    96'(core_start),    96'(3'b010));
    check("pend_active",   96'(active_core),   96'd1);
    check("pend_busy",     96'(busy),          96'd1);
    tick();
    check("start_width",   96'(core_start),    96'd0);
    run_until(launch_cyc + 9);
    core_done = 3'b010;
    tick();
    core_done = '0;
    check("c1_cnt",        96'(cycle_count),   96'd10);
    check("c1_done",       96'(done_latched),  96'd1);
    check("c1_busy",       96'(busy),          96'd0);
    tick();
    tick();
    check("pend_cleared",  96'(core_start),    96'd0);

    // Core 2 run: foreign writes, mode_sel, start/clear and foreign done all ignored.
    mode_sel = 3'd2;
    pulse_start();
    launch_cyc = cyc;
    check("c2_start",      96'(core_start),    96'(3'b100));
    check("c2_active",     96'(active_core),   96'd2);
    check("c2_cnt0",       96'(cycle_count),   96'd0);
    check("c2_done0",      96'(done_latched),  96'd0);
    core_we = 3'b001;
    #1;
    check("foreign_we",    96'(mem_out_we),    96'd0);
    check("c2_raddr",      96'(mem_in_raddr),  96'h0C2);
    core_we = 3'b101;
    #1;
    check("c2_we",         96'(mem_out_we),    96'd1);
    check("c2_waddr",      96'(mem_out_waddr), 96'h222);
    check("c2_wdata",      96'(mem_out_wdata), 96'h5C);
    mode_sel  = 3'd0;
    start_req = 1'b1;
    clear_req = 1'b1;
    core_done = 3'b001;
    tick();
    start_req = 1'b0;
    clear_req = 1'b0;
    core_done = '0;
    check("mid_nostart",   96'(core_start),    96'd0);
    check("mid_active",    96'(active_core),   96'd2);
    check("mid_busy",      96'(busy),          96'd1);
    check("mid_waddr",     96'(mem_out_waddr), 96'h222);
    check("mid_done",      96'(done_latched),  96'd0);
    run_until(launch_cyc + 499);
    core_done = 3'b100;
    tick();
    core_done = '0;
    core_we   = '0;
    check("c2_busy",       96'(busy),          96'd0);
    check("c2_done",       96'(done_latched),  96'd1);
    check("c2_cnt",        96'(cycle_count),   96'd500);
    check("c2_perf",       perf_out,           PERF2);
    check("c2_err",        96'(err_flags),     96'd0);

    // Watchdog on core 0.
    mode_sel = 3'd0;
    pulse_start();
    launch_cyc = cyc;
    check("c0_start",      96'(core_start),    96'(3'b001));
    run_until(launch_cyc + 999);
    check("wd_cnt999",     96'(cycle_count),   96'd999);
    check("wd_noabort",    96'(core_abort),    96'd0);
    tick();
    check("wd_abort",      96'(core_abort),    96'(3'b001));
    check("wd_err",        96'(err_flags),     96'(2'b10));
    check("wd_busy",       96'(busy),          96'd0);
    check("wd_done",       96'(done_latched),  96'd0);
    tick();
    check("wd_abort_w",    96'(core_abort),    96'd0);

    // Done on the watchdog's final cycle wins.
    mode_sel = 3'd1;
    pulse_start();
    launch_cyc = cyc;
    run_until(launch_cyc + 999);
    core_done = 3'b010;
    tick();
    core_done = '0;
    check("tie_abort",     96'(core_abort),    96'd0);
    check("tie_done",      96'(done_latched),  96'd1);
    check("tie_err",       96'(err_flags),     96'd0);
    check("tie_cnt",       96'(cycle_count),   96'd1000);

    // Out-of-range mode, then simultaneous clear and start.
    mode_sel = 3'd5;
    pulse_start();
    check("bad_nostart",   96'(core_start),    96'd0);
    check("bad_err",       96'(err_flags),     96'(2'b01));
    check("bad_busy",      96'(busy),          96'd0);
    check("bad_active",    96'(active_core),   96'd1);
    mode_sel  = 3'd1;
    clear_req = 1'b1;
    start_req = 1'b1;
    tick();
    clear_req = 1'b0;
    start_req = 1'b0;
    clear_sweep(-1);
    check("clr2_busy",     96'(busy),          96'd0);
    check("clr2_nostart",  96'(core_start),    96'd0);
    check("clr2_err_hold", 96'(err_flags),     96'(2'b01));
    tick();
    check("clr2_start",    96'(core_start),    96'(3'b010));
    check("clr2_err",      96'(err_flags),     96'd0);

    // Reset in the middle of a run.
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy",     96'(busy),          96'd1);
    check("mrst_active",   96'(active_core),   96'd0);
    check("mrst_cnt",      96'(cycle_count),   96'd0);
    check("mrst_we",       96'(mem_out_we),    96'd1);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
